// File: rtl/int_div_sign_adapter.sv
// Signed-division wrapper around an unsigned iterative divider: converts operands to
// magnitudes on the way in and applies RISC-V DIV/REM sign rules on the way out.
module int_div_sign_adapter #(
  parameter int nbits     = 64,
  parameter int tag_depth = 2
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*nbits-1:0] req_msg,
  input  logic               req_signed,

  output logic               div_req_val,
  input  logic               div_req_rdy,
  output logic [2*nbits-1:0] div_req_msg,

  input  logic               div_resp_val,
  output logic               div_resp_rdy,
  input  logic [2*nbits-1:0] div_resp_msg,

  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [2*nbits-1:0] resp_msg
);

  localparam int PW = $clog2(tag_depth);
  localparam int CW = $clog2(tag_depth + 1);

  // Tag bit positions: {neg_q, neg_r, div_zero}
  localparam int TAG_NEG_Q = 2;
  localparam int TAG_NEG_R = 1;

  logic [nbits-1:0]   w_dividend;
  logic [nbits-1:0]   w_divisor;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic               w_div_zero;
  logic [nbits-1:0]   w_dvd_mag;
  logic [nbits-1:0]   w_dvs_mag;
  logic [2:0]         w_tag_in;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_resp_hs;
  logic               w_pop;
  logic [2:0]         w_head_tag;

  logic [nbits-1:0]   w_uq;
  logic [nbits-1:0]   w_ur;
  logic [nbits-1:0]   w_q;
  logic [nbits-1:0]   w_r;

  logic [2:0]         r_tags [tag_depth];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_resp_val;
  logic [2*nbits-1:0] r_resp_msg;

  // ---------------- request path (combinational) ----------------
  assign w_dividend = req_msg[nbits-1:0];
  assign w_divisor  = req_msg[2*nbits-1:nbits];
  assign w_dvd_neg  = req_signed & w_dividend[nbits-1];
  assign w_dvs_neg  = req_signed & w_divisor[nbits-1];
  assign w_div_zero = (w_divisor == '0);

  // MIN_INT negates to itself, which is the correct magnitude when read unsigned
  assign w_dvd_mag = w_dvd_neg ? -w_dividend : w_dividend;
  assign w_dvs_mag = w_dvs_neg ? -w_divisor  : w_divisor;

  // Divide-by-zero keeps the divider's all-ones quotient un-negated
  assign w_tag_in = {(w_dvd_neg ^ w_dvs_neg) & ~w_div_zero, w_dvd_neg, w_div_zero};

  assign w_full  = (r_count == CW'(tag_depth));
  assign w_empty = (r_count == '0);

  // Handshakes are forced low while reset is held so nothing leaks through
  assign div_req_val = req_val & ~w_full & ~reset;
  assign req_rdy     = div_req_rdy & ~w_full & ~reset;
  assign div_req_msg = {w_dvs_mag, w_dvd_mag};
  assign w_push      = req_val & req_rdy;

  // ---------------- sign-tag FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= w_tag_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // A response with no outstanding tag is a protocol error; fall back to a zero tag
  assign w_head_tag = w_empty ? 3'b000 : r_tags[r_rd_ptr];

  // ---------------- response path ----------------
  assign div_resp_rdy = ~r_resp_val | resp_rdy;
  assign w_resp_hs    = div_resp_val & div_resp_rdy;
  assign w_pop        = w_resp_hs & ~w_empty;

  assign w_uq = div_resp_msg[2*nbits-1:nbits];
  assign w_ur = div_resp_msg[nbits-1:0];
  assign w_q  = w_head_tag[TAG_NEG_Q] ? -w_uq : w_uq;
  assign w_r  = w_head_tag[TAG_NEG_R] ? -w_ur : w_ur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_val <= 1'b0;
      r_resp_msg <= '0;
    end else if (w_resp_hs) begin
      r_resp_val <= 1'b1;
      r_resp_msg <= {w_q, w_r};
    end else if (resp_rdy) begin
      r_resp_val <= 1'b0;
    end
  end

  assign resp_val = r_resp_val;
  assign resp_msg = r_resp_msg;

  a_no_resp_without_tag: assert property (
    @(posedge clk) disable iff (reset) w_resp_hs |-> !w_empty
  );

endmodule

// File: tb/tb_int_div_sign_adapter.sv
// Directed bench for int_div_sign_adapter; the bench itself plays the unsigned divider.
module tb_int_div_sign_adapter;

  localparam int NB = 64;

  logic            clk;
  logic            reset;
  logic            req_val;
  logic            req_rdy;
  logic [2*NB-1:0] req_msg;
  logic            req_signed;
  logic            div_req_val;
  logic            div_req_rdy;
  logic [2*NB-1:0] div_req_msg;
  logic            div_resp_val;
  logic            div_resp_rdy;
  logic [2*NB-1:0] div_resp_msg;
  logic            resp_val;
  logic            resp_rdy;
  logic [2*NB-1:0] resp_msg;

  int n_vec;
  int n_err;

  localparam logic [NB-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [NB-1:0] MIN  = 64'h8000_0000_0000_0000;

  int_div_sign_adapter #(.nbits(NB), .tag_depth(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_msg      (req_msg),
    .req_signed   (req_signed),
    .div_req_val  (div_req_val),
    .div_req_rdy  (div_req_rdy),
    .div_req_msg  (div_req_msg),
    .div_resp_val (div_resp_val),
    .div_resp_rdy (div_resp_rdy),
    .div_resp_msg (div_resp_msg),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_msg     (resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete request/response through the adapter with resp_rdy held high.
  task automatic run_txn(input logic sgn, input logic [NB-1:0] dvd, input logic [NB-1:0] dvs,
                         input logic [NB-1:0] uq, input logic [NB-1:0] ur,
                         output logic [2*NB-1:0] fwd, output logic fwd_ok,
                         output logic [2*NB-1:0] rsp, output logic rsp_ok);
    tick;
    req_val = 1'b1; req_signed = sgn; req_msg = {dvs, dvd};
    div_req_rdy = 1'b1; resp_rdy = 1'b1;
    #1;
    fwd    = div_req_msg;
    fwd_ok = div_req_val & req_rdy;
    tick;
    req_val = 1'b0;
    div_resp_val = 1'b1; div_resp_msg = {uq, ur};
    tick;
    div_resp_val = 1'b0;
    rsp    = resp_msg;
    rsp_ok = resp_val;
    tick;
    $display("txn sgn=%0b dvd=%h dvs=%h fwd=%h resp=%h", sgn, dvd, dvs, fwd, rsp);
  endtask

  task automatic test_reset;
    req_val = 1'b1; div_req_rdy = 1'b1;
    tick; tick;
    n_vec++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL reset_req_rdy got %b want 0", req_rdy); end
    n_vec++; if (div_req_val !== 1'b0) begin n_err++; $display("FAIL reset_div_req_val got %b want 0", div_req_val); end
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL reset_resp_val got %b want 0", resp_val); end
    n_vec++; if (div_resp_rdy !== 1'b1) begin n_err++; $display("FAIL reset_div_resp_rdy got %b want 1", div_resp_rdy); end
    n_vec++; if (resp_msg !== '0) begin n_err++; $display("FAIL reset_resp_msg got %h want 0", resp_msg); end
    req_val = 1'b0;
    #2 reset = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_signed_basic;
    logic [2*NB-1:0] fwd, rsp;
    logic fok, rok;
    run_txn(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd3, 64'd1, fwd, fok, rsp, rok);
    n_vec++; if (fok !== 1'b1) begin n_err++; $display("FAIL neg7_fwd_hs got %b want 1", fok); end
    n_vec++; if (fwd !== {64'd2, 64'd7}) begin n_err++; $display("FAIL neg7_fwd got %h want %h", fwd, {64'd2, 64'd7}); end
    n_vec++; if (rok !== 1'b1) begin n_err++; $display("FAIL neg7_resp_val got %b want 1", rok); end
    n_vec++; if (rsp !== {64'hFFFF_FFFF_FFFF_FFFD, ONES}) begin n_err++; $display("FAIL neg7_resp got %h want %h", rsp, {64'hFFFF_FFFF_FFFF_FFFD, ONES}); end
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL neg7_resp_clear got %b want 0", resp_val); end
    // 7 / -2 : quotient negative, remainder keeps dividend sign (positive)
    run_txn(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd1, fwd, fok, rsp, rok);
    n_vec++; if (fwd !== {64'd2, 64'd7}) begin n_err++; $display("FAIL pos7_fwd got %h want %h", fwd, {64'd2, 64'd7}); end
    n_vec++; if (rsp !== {64'hFFFF_FFFF_FFFF_FFFD, 64'd1}) begin n_err++; $display("FAIL pos7_resp got %h want %h", rsp, {64'hFFFF_FFFF_FFFF_FFFD, 64'd1}); end
  endtask

  task automatic test_unsigned;
    logic [2*NB-1:0] fwd, rsp;
    logic fok, rok;
    run_txn(1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, fwd, fok, rsp, rok);
    n_vec++; if (fwd !== {64'd2, 64'hFFFF_FFFF_FFFF_FFF9}) begin n_err++; $display("FAIL udiv_fwd got %h want %h", fwd, {64'd2, 64'hFFFF_FFFF_FFFF_FFF9}); end
    n_vec++; if (rsp !== {64'h7FFF_FFFF_FFFF_FFFC, 64'd1}) begin n_err++; $display("FAIL udiv_resp got %h want %h", rsp, {64'h7FFF_FFFF_FFFF_FFFC, 64'd1}); end
  endtask

  task automatic test_div_zero;
    logic [2*NB-1:0] fwd, rsp;
    logic fok, rok;
    run_txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, 64'd5, fwd, fok, rsp, rok);
    n_vec++; if (fwd !== {64'd0, 64'd5}) begin n_err++; $display("FAIL sdz_fwd got %h want %h", fwd, {64'd0, 64'd5}); end
    n_vec++; if (rsp !== {ONES, 64'hFFFF_FFFF_FFFF_FFFB}) begin n_err++; $display("FAIL sdz_resp got %h want %h", rsp, {ONES, 64'hFFFF_FFFF_FFFF_FFFB}); end
    run_txn(1'b0, 64'd5, 64'd0, ONES, 64'd5, fwd, fok, rsp, rok);
    n_vec++; if (rsp !== {ONES, 64'd5}) begin n_err++; $display("FAIL udz_resp got %h want %h", rsp, {ONES, 64'd5}); end
  endtask

  task automatic test_overflow;
    logic [2*NB-1:0] fwd, rsp;
    logic fok, rok;
    run_txn(1'b1, MIN, ONES, MIN, 64'd0, fwd, fok, rsp, rok);
    n_vec++; if (fwd !== {64'd1, MIN}) begin n_err++; $display("FAIL ovf_fwd got %h want %h", fwd, {64'd1, MIN}); end
    n_vec++; if (rsp !== {MIN, 64'd0}) begin n_err++; $display("FAIL ovf_resp got %h want %h", rsp, {MIN, 64'd0}); end
  endtask

  task automatic test_backpressure;
    tick;
    resp_rdy = 1'b0; div_req_rdy = 1'b1;
    // A: -7 / 2
    req_val = 1'b1; req_signed = 1'b1; req_msg = {64'd2, 64'hFFFF_FFFF_FFFF_FFF9};
    #1;
    n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_a got %b want 1", req_rdy); end
    tick;
    // B: 12 / -5
    req_msg = {64'hFFFF_FFFF_FFFF_FFFB, 64'd12};
    #1;
    n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_b got %b want 1", req_rdy); end
    tick;
    // C: unsigned 9 / 4, must stall on the full tag FIFO
    req_signed = 1'b0; req_msg = {64'd4, 64'd9};
    #1;
    n_vec++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL bp_full_rdy got %b want 0", req_rdy); end
    n_vec++; if (div_req_val !== 1'b0) begin n_err++; $display("FAIL bp_full_val got %b want 0", div_req_val); end
    div_resp_val = 1'b1; div_resp_msg = {64'd3, 64'd1};
    #1;
    n_vec++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL bp_pop_cycle_rdy got %b want 0", req_rdy); end
    tick;
    n_vec++; if (resp_msg !== {64'hFFFF_FFFF_FFFF_FFFD, ONES}) begin n_err++; $display("FAIL bp_resp_a got %h want %h", resp_msg, {64'hFFFF_FFFF_FFFF_FFFD, ONES}); end
    n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_after_pop got %b want 1", req_rdy); end
    div_resp_msg = {64'd2, 64'd2};
    #1;
    n_vec++; if (div_resp_rdy !== 1'b0) begin n_err++; $display("FAIL bp_resp_stall got %b want 0", div_resp_rdy); end
    tick;
    req_val = 1'b0;
    n_vec++; if (resp_msg !== {64'hFFFF_FFFF_FFFF_FFFD, ONES}) begin n_err++; $display("FAIL bp_resp_hold got %h want %h", resp_msg, {64'hFFFF_FFFF_FFFF_FFFD, ONES}); end
    resp_rdy = 1'b1;
    #1;
    n_vec++; if (div_resp_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", div_resp_rdy); end
    tick;
    n_vec++; if (resp_val !== 1'b1 || resp_msg !== {64'hFFFF_FFFF_FFFF_FFFE, 64'd2}) begin n_err++; $display("FAIL bp_resp_b got %b/%h want 1/%h", resp_val, resp_msg, {64'hFFFF_FFFF_FFFF_FFFE, 64'd2}); end
    div_resp_msg = {64'd2, 64'd1};
    tick;
    div_resp_val = 1'b0;
    n_vec++; if (resp_val !== 1'b1 || resp_msg !== {64'd2, 64'd1}) begin n_err++; $display("FAIL bp_resp_c got %b/%h want 1/%h", resp_val, resp_msg, {64'd2, 64'd1}); end
    tick;
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", resp_val); end
    $display("txn backpressure A/B/C drained");
  endtask

  task automatic test_async_reset;
    logic [2*NB-1:0] fwd, rsp;
    logic fok, rok;
    tick;
    resp_rdy = 1'b0; div_req_rdy = 1'b1;
    req_val = 1'b1; req_signed = 1'b1; req_msg = {64'hFFFF_FFFF_FFFF_FFFE, 64'd7};
    tick; tick;
    div_resp_val = 1'b1; div_resp_msg = {64'd3, 64'd1};
    tick;
    div_resp_val = 1'b0;
    n_vec++; if (resp_val !== 1'b1 || req_rdy !== 1'b1) begin n_err++; $display("FAIL ar_pre got val=%b rdy=%b want 1/1", resp_val, req_rdy); end
    #3 reset = 1'b1;
    #1;
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL ar_resp_val got %b want 0", resp_val); end
    n_vec++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL ar_req_rdy got %b want 0", req_rdy); end
    n_vec++; if (div_req_val !== 1'b0) begin n_err++; $display("FAIL ar_div_req_val got %b want 0", div_req_val); end
    n_vec++; if (resp_msg !== '0) begin n_err++; $display("FAIL ar_resp_msg got %h want 0", resp_msg); end
    req_val = 1'b0;
    tick; tick;
    #2 reset = 1'b0;
    run_txn(1'b1, 64'd12, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 64'd2, fwd, fok, rsp, rok);
    n_vec++; if (fwd !== {64'd5, 64'd12}) begin n_err++; $display("FAIL ar_fwd got %h want %h", fwd, {64'd5, 64'd12}); end
    n_vec++; if (rok !== 1'b1 || rsp !== {64'hFFFF_FFFF_FFFF_FFFE, 64'd2}) begin n_err++; $display("FAIL ar_resp got %b/%h want 1/%h", rok, rsp, {64'hFFFF_FFFF_FFFF_FFFE, 64'd2}); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    req_val = 1'b0; req_msg = '0; req_signed = 1'b0;
    div_req_rdy = 1'b0;
    div_resp_val = 1'b0; div_resp_msg = '0;
    resp_rdy = 1'b0;
    test_reset;
    test_signed_basic;
    test_unsigned;
    test_div_zero;
    test_overflow;
    test_backpressure;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
